// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame sequencer: FSM state encoding
// and parity type constants.
package uart_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator for one frame payload; odd parity inverts the
// plain XOR of the data bits.
module uart_tx_ctrl_parity_calc
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PAR_TYP,
  output logic                  par_bit
);

  logic data_xor;

  assign data_xor = ^data;

  always_comb begin
    par_bit = data_xor;
    unique case (PAR_TYP)
      EVEN:    par_bit = data_xor;
      ODD:     par_bit = ~data_xor;
      default: par_bit = data_xor;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: holds the byte for the external serializer and
// muxes start/data/parity/stop onto TX_OUT. Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_pdata,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  par_bit_q;
  logic                  par_en_q;
  logic                  par_bit_calc;
  logic                  accept;

`ifdef UART_TX_TWO_STOP_EN
  logic                  stop_cnt_q, stop_cnt_d;
`endif

  uart_tx_ctrl_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (P_DATA),
    .PAR_TYP (PAR_TYP),
    .par_bit (par_bit_calc)
  );

  // Requests outside IDLE are dropped, not queued.
  assign accept    = Data_Valid && (state_q == IDLE);
  assign ser_pdata = pdata_q;
  assign Busy      = (state_q != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      pdata_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pdata_q   <= P_DATA;
        par_bit_q <= par_bit_calc;
        par_en_q  <= PAR_EN;
      end
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stop_cnt_q <= 1'b0;
    end else begin
      stop_cnt_q <= stop_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ser_en  = 1'b0;
    TX_OUT  = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d = START;
        end
      end
      START: begin
        TX_OUT  = 1'b0;
        ser_en  = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        // Dropping ser_en in the done cycle clears the serializer counter.
        TX_OUT = ser_data;
        ser_en = !ser_done;
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        TX_OUT  = par_bit_q;
        state_d = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (stop_cnt_q) begin
          stop_cnt_d = 1'b0;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural serializer and a frame-level
// reference model; directed test-plan frames followed by randomized requests.
module tb_uart_tx_ctrl;

  typedef struct {
    int          start;
    int          len;
    logic [15:0] bits;
    logic [7:0]  data;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_done;
  logic       ser_data;
  logic       ser_en;
  logic [7:0] ser_pdata;
  logic       TX_OUT;
  logic       Busy;

  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_cnt = 0;
  int         free_edge = 0;
  frame_t     exp_q[$];
  bit         abort = 1'b0;

  bit          in_frame = 1'b0;
  int          start_c = 0;
  int          nbits = 0;
  logic [15:0] cap = '0;

  logic [3:0] s_cnt;

  uart_tx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_done   (ser_done),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .ser_pdata  (ser_pdata),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Behavioural 8-bit serializer: registered bit output, done at count 8.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_cnt    <= 4'd0;
      ser_data <= 1'b0;
    end else if (!ser_en) begin
      s_cnt <= 4'd0;
    end else begin
      ser_data <= ser_pdata[s_cnt[2:0]];
      s_cnt    <= s_cnt + 4'd1;
    end
  end
  assign ser_done = (s_cnt == 4'd8);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic frame_t make_frame(input int start, input logic [7:0] d,
                                        input logic pen, input logic pt);
    frame_t f;
    int ones = 0;
    int idx = 0;
    f.start = start;
    f.data  = d;
    f.bits  = '0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    f.bits[idx] = 1'b0; idx++;
    for (int i = 0; i < 8; i++) begin f.bits[idx] = d[i]; idx++; end
    if (pen) begin f.bits[idx] = ((ones % 2) == 1) ^ pt; idx++; end
    f.bits[idx] = 1'b1; idx++;
`ifdef UART_TX_TWO_STOP_EN
    f.bits[idx] = 1'b1; idx++;
`endif
    f.len = idx;
    return f;
  endfunction

  // Issues a one-cycle request; the model decides whether the DUT accepts it.
  task automatic pulse(input logic [7:0] d, input logic pen, input logic pt);
    int n;
    frame_t f;
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pen; PAR_TYP = pt; Data_Valid = 1'b1;
    n = edge_cnt + 1;
    if (n >= free_edge) begin
      f = make_frame(n, d, pen, pt);
      exp_q.push_back(f);
      free_edge = n + f.len + 1;
    end
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic finish_frame();
    frame_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'(nbits), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("frame_start", 32'(start_c), 32'(e.start));
      check("frame_len", 32'(nbits), 32'(e.len));
      check("frame_bits", {16'd0, cap}, {16'd0, e.bits});
    end
  endtask

  always @(negedge CLK) begin
    if (abort) begin
      in_frame = 1'b0;
      nbits    = 0;
      cap      = '0;
    end else if (Busy) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        start_c  = edge_cnt;
        nbits    = 0;
        cap      = '0;
      end
      if (nbits < 16) cap[nbits] = TX_OUT;
      nbits++;
      if (exp_q.size() != 0) check("ser_pdata_hold", 32'(ser_pdata), 32'(exp_q[0].data));
    end else begin
      if (in_frame) finish_frame();
      in_frame = 1'b0;
      check("idle_tx_out", 32'(TX_OUT), 32'd1);
      check("idle_ser_en", 32'(ser_en), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_tx_out", 32'(TX_OUT), 32'd1);
    check("rst_ser_en", 32'(ser_en), 32'd0);
    check("rst_ser_pdata", 32'(ser_pdata), 32'd0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);

    // A5 even / odd parity, 3C without parity.
    pulse(8'hA5, 1'b1, 1'b0);
    repeat (15) @(posedge CLK);
    pulse(8'hA5, 1'b1, 1'b1);
    repeat (15) @(posedge CLK);
    pulse(8'h3C, 1'b0, 1'b0);
    // Request mid-DATA is dropped.
    repeat (3) @(posedge CLK);
    pulse(8'hFF, 1'b1, 1'b1);
    repeat (12) @(posedge CLK);

    // Back-to-back: request in the first IDLE cycle after STOP.
    pulse(8'h5A, 1'b0, 1'b0);
    k = free_edge - edge_cnt - 2;
    repeat (k) @(posedge CLK);
    pulse(8'hC3, 1'b1, 1'b0);
    // Request during STOP is dropped.
    k = free_edge - edge_cnt - 3;
    repeat (k) @(posedge CLK);
    pulse(8'h77, 1'b1, 1'b1);
    repeat (6) @(posedge CLK);

    // Reset asserted during PARITY aborts the frame immediately.
    pulse(8'hA5, 1'b1, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    abort = 1'b1;
    void'(exp_q.pop_back());
    RST = 1'b0;
    #1;
    check("abort_tx_out", 32'(TX_OUT), 32'd1);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_ser_en", 32'(ser_en), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    abort = 1'b0;
    free_edge = 0;
    pulse(8'h01, 1'b1, 1'b0);
    repeat (14) @(posedge CLK);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 14)) @(posedge CLK);
      pulse(8'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
